// File: rtl/ps2_keyboard_mmio_if.sv
// CPU memory-mapped bus between the CPU (master) and the PS/2 keyboard peripheral (slave).
// Handshake: mem_read and mem_write are one-cycle strobes sampled on the rising clk edge.
// mem_rdata answers a read on the following edge and holds while mem_read is low.
// irq is a registered level.
interface ps2_keyboard_mmio_if #(parameter int ADDR_W = 8);
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              irq;

   modport master (output mem_read, mem_write, mem_addr, mem_wdata, input mem_rdata, irq);
   modport slave  (input mem_read, mem_write, mem_addr, mem_wdata, output mem_rdata, irq);
endinterface

// File: rtl/ps2_keyboard_mmio.sv
// PS/2 keyboard peripheral: frame receiver with parity/timeout checks, set-2 prefix decoder,
// event FIFO, live A-Z key bitmap and level interrupt behind a four-register map.
module ps2_keyboard_mmio #(
   parameter int FIFO_DEPTH     = 16,
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               ps2_clk,
   input  logic               ps2_data,
   ps2_keyboard_mmio_if.slave bus,
   output logic [1:0]         rx_state
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

   // Bit 5 flags a letter; bits 4:0 give its position A=0 .. Z=25.
   function automatic logic [5:0] letter_lookup(input logic [7:0] code);
      logic [5:0] r;
      r = '0;
      case (code)
         8'h1C: r = 6'd32;  8'h32: r = 6'd33;  8'h21: r = 6'd34;  8'h23: r = 6'd35;
         8'h24: r = 6'd36;  8'h2B: r = 6'd37;  8'h34: r = 6'd38;  8'h33: r = 6'd39;
         8'h43: r = 6'd40;  8'h3B: r = 6'd41;  8'h42: r = 6'd42;  8'h4B: r = 6'd43;
         8'h3A: r = 6'd44;  8'h31: r = 6'd45;  8'h44: r = 6'd46;  8'h4D: r = 6'd47;
         8'h15: r = 6'd48;  8'h2D: r = 6'd49;  8'h1B: r = 6'd50;  8'h2C: r = 6'd51;
         8'h3C: r = 6'd52;  8'h2A: r = 6'd53;  8'h1D: r = 6'd54;  8'h22: r = 6'd55;
         8'h35: r = 6'd56;  8'h1A: r = 6'd57;
         default: r = '0;
      endcase
      return r;
   endfunction

   logic [1:0]    clk_sync, data_sync;
   logic          clk_prev, fall, bit_in;
   rx_state_t     state, state_next;
   logic [2:0]    bit_cnt, bit_cnt_next;
   logic [7:0]    shreg, shreg_next;
   logic          par_bad, par_bad_next, byte_valid, byte_valid_next;
   logic          par_set, frm_set, timeout;
   logic [TW-1:0] to_cnt;
   logic          pend_ext, pend_brk, emit;
   logic [9:0]    evt;
   logic [5:0]    hit_idx;
   logic [25:0]   keys;
   logic [9:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          not_empty, full, rd_event, wr_ctrl, flush, clr, pop, push_req, do_push, ovf_set;
   logic          overflow, parity_err, frame_err, irq_en;
   logic [31:0]   rdata_next;
   logic          unused_wdata;

   assign unused_wdata = ^bus.mem_wdata[31:3];
   assign rx_state     = state;
   assign fall         = clk_prev & ~clk_sync[1];
   assign bit_in       = data_sync[1];
   assign timeout      = (state != IDLE) && (to_cnt == TO_MAX);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
         to_cnt    <= '0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_prev  <= clk_sync[1];
         if (fall) to_cnt <= '0;
         else if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bad    <= 1'b0;
         byte_valid <= 1'b0;
      end else begin
         state      <= state_next;
         bit_cnt    <= bit_cnt_next;
         shreg      <= shreg_next;
         par_bad    <= par_bad_next;
         byte_valid <= byte_valid_next;
      end
   end

   always_comb begin
      state_next      = state;
      bit_cnt_next    = bit_cnt;
      shreg_next      = shreg;
      par_bad_next    = par_bad;
      byte_valid_next = 1'b0;
      par_set         = 1'b0;
      frm_set         = 1'b0;
      if (fall) begin
         case (state)
            IDLE: if (!bit_in) begin
               state_next   = DATA;
               bit_cnt_next = '0;
            end
            DATA: begin
               shreg_next   = {bit_in, shreg[7:1]};
               bit_cnt_next = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) state_next = PARITY;
            end
            PARITY: begin
               par_bad_next = ~^{shreg, bit_in};
               par_set      = ~^{shreg, bit_in};
               state_next   = STOP;
            end
            STOP: begin
               state_next = IDLE;
               if (!bit_in) frm_set = 1'b1;
               else if (!par_bad) byte_valid_next = 1'b1;
            end
            default: state_next = IDLE;
         endcase
      end else if (timeout) begin
         state_next = IDLE;
         frm_set    = 1'b1;
      end
   end

   // shreg stays stable in IDLE, so the decoder reads the byte straight from it.
   assign emit    = byte_valid && (shreg != 8'hE0) && (shreg != 8'hF0);
   assign evt     = {pend_ext, pend_brk, shreg};
   assign hit_idx = letter_lookup(shreg);

   assign not_empty = (count != '0);
   assign full      = (count == FULL_CNT);
   assign rd_event  = bus.mem_read && (bus.mem_addr == ADDR_W'(1));
   assign wr_ctrl   = bus.mem_write && (bus.mem_addr == ADDR_W'(3));
   assign flush     = wr_ctrl && bus.mem_wdata[1];
   assign clr       = wr_ctrl && bus.mem_wdata[2];
   assign pop       = rd_event && not_empty;
   assign push_req  = emit && !flush;
   assign do_push   = push_req && (!full || pop);
   assign ovf_set   = push_req && full && !pop;

   always_ff @(posedge clk) begin
      if (do_push) fifo_mem[wr_ptr] <= evt;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pend_ext <= 1'b0;
         pend_brk <= 1'b0;
         keys     <= '0;
      end else if (byte_valid) begin
         if (shreg == 8'hE0) pend_ext <= 1'b1;
         else if (shreg == 8'hF0) pend_brk <= 1'b1;
         else begin
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
            if (!pend_ext && hit_idx[5]) keys[hit_idx[4:0]] <= ~pend_brk;
         end
      end
   end

   always_comb begin
      rdata_next = '0;
      case (bus.mem_addr)
         ADDR_W'(0): rdata_next = {16'h0, 8'(count), 3'b0, frame_err, parity_err, overflow, full, not_empty};
         ADDR_W'(1): if (not_empty) rdata_next = {1'b1, 21'h0, fifo_mem[rd_ptr]};
         ADDR_W'(2): rdata_next = {6'h0, keys};
         ADDR_W'(3): rdata_next = {31'h0, irq_en};
         default:    rdata_next = '0;
      endcase
   end

   // A new error in the same cycle as a clear keeps its sticky bit set.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         overflow      <= 1'b0;
         parity_err    <= 1'b0;
         frame_err     <= 1'b0;
         irq_en        <= 1'b0;
         bus.irq       <= 1'b0;
         bus.mem_rdata <= '0;
      end else begin
         overflow   <= (overflow & ~clr) | ovf_set;
         parity_err <= (parity_err & ~clr) | par_set;
         frame_err  <= (frame_err & ~clr) | frm_set;
         if (wr_ctrl) irq_en <= bus.mem_wdata[0];
         bus.irq <= irq_en & not_empty;
         if (bus.mem_read) bus.mem_rdata <= rdata_next;
      end
   end
endmodule

// File: tb/tb_ps2_keyboard_mmio.sv
// Bench for ps2_keyboard_mmio: PS/2 frame driver, bus driver tasks, a queue-based
// reference model of the keyboard, and a read monitor scoring mem_rdata against exp_q.
module tb_ps2_keyboard_mmio;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 8;
   localparam int TO_CYC = 300;
   localparam logic [ADDR_W-1:0] A_STATUS = 0, A_EVENT = 1, A_KEYS = 2, A_CTRL = 3;
   localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
      8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

   logic clk = 1'b0, reset_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [1:0] rx_state;
   int checks = 0, failures = 0;
   logic [31:0] exp_q [$];
   string       tag_q [$];

   // Reference model state
   logic [9:0]  m_fifo [$];
   logic        m_ovf, m_par, m_frm, m_ext, m_brk, m_irq_en;
   logic [25:0] m_keys;

   ps2_keyboard_mmio_if #(.ADDR_W(ADDR_W)) bus ();

   ps2_keyboard_mmio #(.FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .bus(bus), .rx_state(rx_state));

   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: run did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every sampled read is scored on the following falling edge.
   initial forever begin
      @(posedge clk);
      if (bus.mem_read === 1'b1) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL monitor: unexpected read data 0x%08h required none", bus.mem_rdata);
         end else check(tag_q.pop_front(), bus.mem_rdata, exp_q.pop_front());
      end
   end

   task automatic model_reset();
      m_fifo.delete();
      m_ovf = 0; m_par = 0; m_frm = 0; m_ext = 0; m_brk = 0; m_irq_en = 0; m_keys = '0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         if (m_fifo.size() == DEPTH) m_ovf = 1;
         else m_fifo.push_back({m_ext, m_brk, b});
         if (!m_ext) for (int i = 0; i < 26; i++) if (LETTERS[i] == b) m_keys[i] = !m_brk;
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   function automatic logic [31:0] m_status();
      return {16'h0, 8'(m_fifo.size()), 3'b0, m_frm, m_par, m_ovf,
              m_fifo.size() == DEPTH, m_fifo.size() != 0};
   endfunction

   task automatic bus_read(input logic [ADDR_W-1:0] a, input logic [31:0] e, input string tag);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      bus.mem_read = 1'b1;
      bus.mem_addr = a;
      @(negedge clk);
      bus.mem_read = 1'b0;
   endtask

   task automatic rd_event();
      logic [31:0] e;
      logic [9:0]  ev;
      e = '0;
      if (m_fifo.size() != 0) begin
         ev = m_fifo.pop_front();
         e = {1'b1, 21'h0, ev};
      end
      bus_read(A_EVENT, e, "event");
   endtask

   task automatic rd_status(); bus_read(A_STATUS, m_status(), "status"); endtask
   task automatic rd_keys();   bus_read(A_KEYS, {6'h0, m_keys}, "keys"); endtask
   task automatic rd_ctrl();   bus_read(A_CTRL, {31'h0, m_irq_en}, "ctrl"); endtask

   task automatic wr_ctrl(input logic [31:0] v);
      bus.mem_write = 1'b1;
      bus.mem_addr  = A_CTRL;
      bus.mem_wdata = v;
      @(negedge clk);
      bus.mem_write = 1'b0;
      m_irq_en = v[0];
      if (v[1]) m_fifo.delete();
      if (v[2]) begin m_ovf = 0; m_par = 0; m_frm = 0; end
   endtask

   task automatic ps2_bit(input logic v);
      ps2_data = v;
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (5) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   // pop_sync lines an EVENT read up with the push edge of this frame's byte.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit pop_sync);
      logic p;
      p = ~(^b) ^ bad_par;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(p);
      if (!pop_sync) ps2_bit(!bad_stop);
      else begin
         ps2_data = 1'b1;
         repeat (5) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (3) @(negedge clk);
         rd_event();
         @(negedge clk);
         ps2_clk = 1'b1;
      end
      repeat (6) @(negedge clk);
      if (bad_par) m_par = 1;
      else if (bad_stop) m_frm = 1;
      else model_byte(b);
   endtask

   task automatic send_partial(input logic [7:0] b, input int n);
      ps2_bit(1'b0);
      for (int i = 0; i < n; i++) ps2_bit(b[i]);
   endtask

   initial begin
      int r;
      int li;
      bus.mem_read = 0; bus.mem_write = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_rdata", bus.mem_rdata, 32'h0);
      check("reset_irq", {31'h0, bus.irq}, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);
      rd_status(); rd_keys(); rd_ctrl(); rd_event();

      // Single make, break, extended break
      send_frame(8'h1C, 0, 0, 0);
      rd_status(); rd_event(); rd_status(); rd_keys();
      repeat (3) @(negedge clk);
      check("rdata_hold", bus.mem_rdata, {6'h0, m_keys});
      send_frame(8'hF0, 0, 0, 0); send_frame(8'h1C, 0, 0, 0);
      rd_event(); rd_keys();
      send_frame(8'h32, 0, 0, 0);
      send_frame(8'hE0, 0, 0, 0); send_frame(8'hF0, 0, 0, 0); send_frame(8'h75, 0, 0, 0);
      rd_event(); rd_event(); rd_keys();

      // Parity and timeout errors, sticky clear
      send_frame(8'h1C, 1, 0, 0);
      rd_status(); rd_event();
      wr_ctrl(32'h4);
      rd_status();
      send_partial(8'h1C, 4);
      repeat (TO_CYC + 30) @(negedge clk);
      m_frm = 1;
      rd_status(); rd_event();
      send_frame(8'h32, 0, 0, 0);
      rd_event();
      send_frame(8'h21, 0, 1, 0);
      rd_status();
      wr_ctrl(32'h4);

      // Overflow with DEPTH+1 makes
      for (int i = 0; i <= DEPTH; i++) send_frame(LETTERS[i + 2], 0, 0, 0);
      rd_status();
      for (int i = 0; i <= DEPTH; i++) rd_event();
      rd_status(); rd_keys();

      // Interrupt set and clear
      wr_ctrl(32'h5);
      rd_ctrl();
      repeat (2) @(negedge clk);
      check("irq_idle", {31'h0, bus.irq}, 32'h0);
      send_frame(8'h24, 0, 0, 0);
      check("irq_event", {31'h0, bus.irq}, 32'h1);
      rd_event();
      check("irq_pop_edge", {31'h0, bus.irq}, 32'h1);
      @(negedge clk);
      check("irq_cleared", {31'h0, bus.irq}, 32'h0);

      // Push coinciding with pop while full
      for (int i = 0; i < DEPTH; i++) send_frame(LETTERS[i + 10], 0, 0, 0);
      rd_status();
      send_frame(LETTERS[20], 0, 0, 1);
      rd_status();
      check("irq_full", {31'h0, bus.irq}, 32'h1);
      for (int i = 0; i < DEPTH; i++) rd_event();
      rd_status();

      // Reset during a frame after an E0 prefix
      send_frame(8'hE0, 0, 0, 0);
      send_partial(8'h1C, 3);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      send_frame(8'h1C, 0, 0, 0);
      rd_event(); rd_ctrl(); rd_keys();

      // Randomized traffic
      wr_ctrl(32'h1);
      for (int it = 0; it < 60; it++) begin
         r  = $urandom_range(0, 7);
         li = $urandom_range(0, 25);
         case (r)
            0, 1, 2: begin
               if ($urandom_range(0, 1) == 1) send_frame(8'hE0, 0, 0, 0);
               if ($urandom_range(0, 1) == 1) send_frame(8'hF0, 0, 0, 0);
               send_frame(LETTERS[li], 0, 0, 0);
            end
            3: send_frame(8'($urandom_range(0, 255)), 0, 0, 0);
            4: rd_event();
            5: rd_status();
            6: rd_keys();
            default: send_frame(LETTERS[li], 1, 0, 0);
         endcase
      end
      rd_status(); rd_keys();
      repeat (2) @(negedge clk);
      check("irq_final", {31'h0, bus.irq}, {31'h0, m_irq_en && (m_fifo.size() != 0)});

      repeat (4) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending reads required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
